// File: rtl/sram_loader_pkg.sv
// ============================================================================
// Module      : sram_loader_pkg
// Description : Shared state encoding and constants for the SRAM block loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } loader_state_t;

    localparam int WORDS_PER_BLOCK = 32;
    localparam int MEM_LAT_MIN     = 1;
    localparam int MEM_LAT_MAX     = 3;

    function automatic bit mem_lat_legal(input int lat);
        return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/loader_delay_line.sv
// ============================================================================
// Module      : loader_delay_line
// Description : DEPTH-stage shift register carrying a valid bit and a word
//               index alongside each outstanding SRAM read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module loader_delay_line #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [IDX_W-1:0] i_idx,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    logic             r_valid [DEPTH];
    logic [IDX_W-1:0] r_idx   [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_idx[i]   <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_idx[0]   <= i_idx;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_idx[i]   <= r_idx[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_idx   = r_idx[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/sram_block_loader.sv
// ============================================================================
// Module      : sram_block_loader
// Description : Copies one 32-word SRAM block into the register file at one
//               word per cycle. Optional running checksum output is enabled
//               with `define SRAM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_block_loader
    import sram_loader_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 7,
    parameter int RF_ADDR_W  = 5,
    parameter int MEM_LAT    = 1
) (
    input  logic                          CLOCK_50,
    input  logic                          nReset,
    input  logic                          start,
    input  logic [MEM_ADDR_W-RF_ADDR_W-1:0] blockSel,
    output logic                          busy,
    output logic                          done,
    output logic                          nMemOut,
    output logic [MEM_ADDR_W-1:0]         memAdd,
    input  logic [DATA_W-1:0]             memData,
    output logic [RF_ADDR_W-1:0]          writeSel,
    output logic [DATA_W-1:0]             data,
    output logic                          we
`ifdef SRAM_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]             checksum
`endif
);

    localparam logic [RF_ADDR_W-1:0] c_last_idx = {RF_ADDR_W{1'b1}};

    generate
        if (!mem_lat_legal(MEM_LAT) || ((1 << RF_ADDR_W) != WORDS_PER_BLOCK)) begin : g_param_check
            $error("sram_block_loader: illegal MEM_LAT or RF_ADDR_W");
        end
    endgenerate

    loader_state_t          r_state;
    logic [RF_ADDR_W-1:0]   r_k;
    logic                   w_issue_valid;
    logic                   w_cap_valid;
    logic [RF_ADDR_W-1:0]   w_cap_idx;

    assign w_issue_valid = (r_state == ST_ISSUE);

    // Tracks which word index each in-flight read belongs to.
    loader_delay_line #(
        .DEPTH (MEM_LAT),
        .IDX_W (RF_ADDR_W)
    ) u_delay_line (
        .clk     (CLOCK_50),
        .rst_n   (nReset),
        .i_valid (w_issue_valid),
        .i_idx   (r_k),
        .o_valid (w_cap_valid),
        .o_idx   (w_cap_idx)
    );

    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            memAdd  <= '0;
            nMemOut <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_ISSUE;
                        memAdd  <= {blockSel, {RF_ADDR_W{1'b0}}};
                        r_k     <= '0;
                        nMemOut <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (r_k == c_last_idx) begin
                        r_state <= ST_DRAIN;
                        nMemOut <= 1'b1;
                    end else begin
                        r_k    <= r_k + RF_ADDR_W'(1);
                        memAdd <= memAdd + MEM_ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // The last word is on the write port this cycle.
                    if (we && (writeSel == c_last_idx)) begin
                        r_state <= ST_FINISH;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Returning read data goes straight to the register-file write port.
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            we       <= 1'b0;
            writeSel <= '0;
            data     <= '0;
        end else begin
            we <= w_cap_valid;
            if (w_cap_valid) begin
                writeSel <= w_cap_idx;
                data     <= memData;
            end
        end
    end

`ifdef SRAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            r_checksum <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_checksum <= '0;
        end else if (we) begin
            r_checksum <= r_checksum + data;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule

`default_nettype wire
